// File: rtl/ss_pkg.sv
// Shared types for the stack-op controller and the ss_io stack port:
// primitive ops, command ops, per-command limits and the primitive sequence table.
package ss_pkg;

  typedef enum logic [1:0] {
    SS_NOP  = 2'd0,
    SS_PUSH = 2'd1,
    SS_POP  = 2'd2
  } ss_op_e;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_PUSH = 3'd1,
    CMD_POP  = 3'd2,
    CMD_DUP  = 3'd3,
    CMD_DROP = 3'd4,
    CMD_SWAP = 3'd5,
    CMD_OVER = 3'd6,
    CMD_ROT  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SRC_ZERO = 3'd0,
    SRC_V    = 3'd1,
    SRC_A    = 3'd2,
    SRC_B    = 3'd3,
    SRC_C    = 3'd4
  } src_e;

  typedef struct packed {
    ss_op_e op;
    src_e   src;
  } prim_t;

  // Indexed by cmd_e; entry 7 is ROT, entry 0 is NOP.
  localparam logic [7:0][2:0] MIN_ITEMS = {3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
  localparam logic [7:0][2:0] SEQ_LEN   = {3'd7, 3'd1, 3'd4, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};

  function automatic logic grows(cmd_e c);
    return (c == CMD_PUSH) || (c == CMD_DUP) || (c == CMD_OVER);
  endfunction

  function automatic prim_t seq_step(cmd_e c, logic [2:0] i);
    prim_t p;
    p = '{op: SS_NOP, src: SRC_ZERO};
    case (c)
      CMD_PUSH:          p = '{op: SS_PUSH, src: SRC_V};
      CMD_POP, CMD_DROP: p = '{op: SS_POP,  src: SRC_ZERO};
      CMD_DUP:           p = '{op: SS_PUSH, src: SRC_A};
      CMD_OVER:          p = '{op: SS_PUSH, src: SRC_B};
      CMD_SWAP: begin
        case (i)
          3'd0, 3'd1: p = '{op: SS_POP,  src: SRC_ZERO};
          3'd2:       p = '{op: SS_PUSH, src: SRC_A};
          default:    p = '{op: SS_PUSH, src: SRC_B};
        endcase
      end
      CMD_ROT: begin
        // Step 2 is an idle slot so the third item is visible on tos for capture.
        case (i)
          3'd0, 3'd1, 3'd3: p = '{op: SS_POP,  src: SRC_ZERO};
          3'd2:             p = '{op: SS_NOP,  src: SRC_ZERO};
          3'd4:             p = '{op: SS_PUSH, src: SRC_B};
          3'd5:             p = '{op: SS_PUSH, src: SRC_A};
          default:          p = '{op: SS_PUSH, src: SRC_C};
        endcase
      end
      default: p = '{op: SS_NOP, src: SRC_ZERO};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ss_io.sv
// Single-primitive stack port: master issues op/vi, stack presents tos and s0 (second item).
interface ss_io #(
  parameter int DSZ = 32
);
  import ss_pkg::*;

  ss_op_e         op;
  logic [DSZ-1:0] vi;
  logic [DSZ-1:0] tos;
  logic [DSZ-1:0] s0;

  modport master (output op, output vi, input tos, input s0);
  modport slave  (input op, input vi, output tos, output s0);
endinterface

// File: rtl/ss_stack.sv
// Simple LIFO store on the slave side of ss_io; tos/s0 read 0 when absent.
module ss_stack
  import ss_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DSZ   = 32
) (
  input logic  clk,
  input logic  rst_n,
  ss_io.slave  ss_if
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [DSZ-1:0] mem [DEPTH];
  logic [DW-1:0]  sp;
  logic [DW-1:0]  sp_m1;
  logic [DW-1:0]  sp_m2;

  assign sp_m1 = sp - DW'(1);
  assign sp_m2 = sp - DW'(2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (ss_if.op == SS_PUSH && sp != DW'(DEPTH)) begin
      sp <= sp + DW'(1);
    end else if (ss_if.op == SS_POP && sp != '0) begin
      sp <= sp_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (ss_if.op == SS_PUSH && sp != DW'(DEPTH)) begin
      mem[sp[AW-1:0]] <= ss_if.vi;
    end
  end

  assign ss_if.tos = (sp != '0)     ? mem[sp_m1[AW-1:0]] : '0;
  assign ss_if.s0  = (sp > DW'(1))  ? mem[sp_m2[AW-1:0]] : '0;

endmodule

// File: rtl/stack_op_ctl.sv
// Stack-op controller: expands one command into a sequence of PUSH/POP primitives
// on ss_io, tracking the item count and rejecting under/overflowing commands.
module stack_op_ctl
  import ss_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DSZ   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [DSZ-1:0]         cmd_v,
  output logic                   rsp_valid,
  output logic [DSZ-1:0]         rsp_v,
  output logic                   err_ovf,
  output logic                   err_unf,
  output logic [$clog2(DEPTH):0] depth,
  ss_io.master                   ss_if
);

  localparam int DW = $clog2(DEPTH) + 1;

  state_e         state;
  cmd_e           cop;
  logic [2:0]     step;
  ss_op_e         op_q;
  logic [DSZ-1:0] vi_q;
  logic [DSZ-1:0] a, b, c, v;

  cmd_e           acc_cmd;
  logic           unf, ovf;
  prim_t          first, nxt;
  logic [2:0]     last_step;

  function automatic logic [DSZ-1:0] sel_val(src_e s, logic [DSZ-1:0] pv, logic [DSZ-1:0] pa,
                                             logic [DSZ-1:0] pb, logic [DSZ-1:0] pc);
    logic [DSZ-1:0] r;
    case (s)
      SRC_V:   r = pv;
      SRC_A:   r = pa;
      SRC_B:   r = pb;
      SRC_C:   r = pc;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Count follows the primitive executing this cycle, clamped to 0..DEPTH.
  function automatic logic [DW-1:0] depth_next(logic [DW-1:0] d, ss_op_e o);
    logic [DW-1:0] r;
    r = d;
    if (o == SS_PUSH && d != DW'(DEPTH)) r = d + DW'(1);
    if (o == SS_POP && d != '0)          r = d - DW'(1);
    return r;
  endfunction

  assign acc_cmd   = cmd_e'(cmd_op);
  assign unf       = depth < DW'(MIN_ITEMS[acc_cmd]);
  assign ovf       = grows(acc_cmd) && (depth == DW'(DEPTH));
  assign first     = seq_step(acc_cmd, 3'd0);
  assign nxt       = seq_step(cop, step + 3'd1);
  assign last_step = SEQ_LEN[cop] - 3'd1;

  assign ss_if.op  = op_q;
  assign ss_if.vi  = vi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      cop       <= CMD_NOP;
      step      <= '0;
      op_q      <= SS_NOP;
      vi_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_v     <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      depth     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_v     <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      depth     <= depth_next(depth, op_q);
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cop       <= acc_cmd;
            step      <= '0;
            cmd_ready <= 1'b0;
            if (unf || ovf || SEQ_LEN[acc_cmd] == 3'd0) begin
              state     <= ST_DONE;
              rsp_valid <= 1'b1;
              err_unf   <= unf;
              err_ovf   <= ovf && !unf;
            end else begin
              state <= ST_RUN;
              op_q  <= first.op;
              vi_q  <= sel_val(first.src, cmd_v, ss_if.tos, ss_if.s0, '0);
            end
          end
        end
        ST_RUN: begin
          if (step == last_step) begin
            state     <= ST_DONE;
            op_q      <= SS_NOP;
            vi_q      <= '0;
            rsp_valid <= 1'b1;
            if (cop == CMD_POP) rsp_v <= a;
          end else begin
            step <= step + 3'd1;
            op_q <= nxt.op;
            vi_q <= sel_val(nxt.src, v, a, b, c);
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && cmd_valid) begin
      a <= ss_if.tos;
      b <= ss_if.s0;
      v <= cmd_v;
    end
    if (state == ST_RUN && cop == CMD_ROT && step == 3'd2) begin
      c <= ss_if.tos;
    end
  end

endmodule
